game_step_ctrl: RTL and testbench

- Sequencer for the Tetris play-field datapath. Owns the field register and the active-piece register.
- Turns player commands and gravity ticks into candidate piece positions and probes each one through check_valid.
- Locks the piece through create_field, then runs the clean_field handshake.
- Keeps score, line and level counters, requests new pieces, and detects game over.

---
 rtl/game_step_ctrl_pkg.sv | 33 +++
 rtl/game_step_ctrl_score_keeper.sv | 59 +++++
 rtl/game_step_ctrl.sv | 173 +++++++++++++++++
 tb/tb_game_step_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_step_ctrl_pkg.sv
// Shared types and constants for the play-field sequencer and its datapath neighbours.
package game_step_ctrl_pkg;

  localparam int FIELD_HORIZONTAL = 10;
  localparam int FIELD_VERTICAL   = 22;

  // Row 0 is the top row; a cell bit of 1 means empty, 0 means occupied.
  typedef logic [FIELD_VERTICAL-1:0][FIELD_HORIZONTAL-1:0] field_t;

  // One 4x4 shape per rotation, cell (r,c) at bit r*4+c; x/y is the box top-left.
  typedef struct packed {
    logic [2:0]       idx;
    logic [3:0][15:0] tetromino;
    logic [1:0]       rotation;
    logic [4:0]       x;
    logic [4:0]       y;
  } tetromino_ctrl;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_LEFT  = 3'd1;
  localparam logic [2:0] CMD_RIGHT = 3'd2;
  localparam logic [2:0] CMD_ROT   = 3'd3;
  localparam logic [2:0] CMD_DOWN  = 3'd4;
  localparam logic [2:0] CMD_HARD  = 3'd5;

  typedef enum logic [2:0] {
    S_SPAWN, S_SPAWN_CHK, S_IDLE, S_PROBE, S_LOCK, S_CLEAN, S_GAMEOVER
  } game_state_t;

  // Base points for 0..4 cleared lines, indexed by line count.
  localparam logic [4:0][9:0] LINE_SCORE = {10'd800, 10'd500, 10'd300, 10'd100, 10'd0};

endpackage

// File: rtl/game_step_ctrl_score_keeper.sv
// Saturating score, line and level counters.
module game_step_ctrl_score_keeper
  import game_step_ctrl_pkg::*;
#(
  parameter int SCORE_W         = 24,
  parameter int LINES_PER_LEVEL = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clean_upd,
  input  logic [2:0]         clean_lines,
  input  logic               drop_inc,
  output logic [SCORE_W-1:0] score,
  output logic [15:0]        lines_total,
  output logic [7:0]         level
);

  localparam int AW = SCORE_W + 20;
  localparam logic [AW-1:0] SCORE_MAX = {{20{1'b0}}, {SCORE_W{1'b1}}};

  logic [2:0]    lc;
  logic [16:0]   lines_sum;
  logic [15:0]   lines_new;
  logic [15:0]   lvl_full;
  logic [7:0]    lvl_new;
  logic [18:0]   gain;
  logic [AW-1:0] add;
  logic [AW-1:0] sum;

  // Next counter values; the wide sum leaves headroom to detect saturation.
  always_comb begin
    lc        = (clean_lines > 3'd4) ? 3'd4 : clean_lines;
    lines_sum = {1'b0, lines_total} + {14'd0, lc};
    lines_new = lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
    lvl_full  = 16'(32'(lines_new) / LINES_PER_LEVEL);
    lvl_new   = (lvl_full > 16'd255) ? 8'hFF : lvl_full[7:0];
    // Multiplier uses the level in force before this clear.
    gain      = 19'(LINE_SCORE[lc]) * 19'({1'b0, level} + 9'd1);
    add       = clean_upd ? AW'(gain) : (drop_inc ? AW'(1) : '0);
    sum       = {20'd0, score} + add;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      score       <= '0;
      lines_total <= '0;
      level       <= '0;
    end else begin
      if (clean_upd || drop_inc)
        score <= (sum > SCORE_MAX) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
      if (clean_upd) begin
        lines_total <= lines_new;
        level       <= lvl_new;
      end
    end
  end

endmodule

// File: rtl/game_step_ctrl.sv
// Play-field sequencer: spawn, move probing, lock, line-clean handshake, game over.
module game_step_ctrl
  import game_step_ctrl_pkg::*;
#(
  parameter int SPAWN_X         = 3,
  parameter int SPAWN_Y         = 0,
  parameter int LINES_PER_LEVEL = 10,
  parameter int SCORE_W         = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd,
  output logic               cmd_ready,
  input  logic               grav_tick,
  input  tetromino_ctrl      next_piece,
  output logic               next_req,
  output tetromino_ctrl      t_probe,
  input  logic               probe_ok,
  output tetromino_ctrl      t_cur,
  output field_t             field_q,
  input  field_t             merged_field,
  output logic               clean_en,
  input  logic               clean_done,
  input  field_t             clean_field_in,
  input  logic [2:0]         clean_lines,
  output logic [SCORE_W-1:0] score,
  output logic [15:0]        lines_total,
  output logic [7:0]         level,
  output logic               game_over,
  output logic               busy
);

  game_state_t   state, state_d;
  tetromino_ctrl t_cur_d, t_probe_d, sp;
  field_t        field_d;
  logic          grav_pend, pend_d;
  logic          hard, hard_d;   // probe is a hard-drop step
  logic          lat, lat_d;     // probe is LEFT/RIGHT/ROT: failure discards instead of locking
  logic          clean_en_d, over_d, next_req_d;
  logic          drop_inc, clean_upd;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE) && (state != S_GAMEOVER);

  // Next-state and datapath next values.
  always_comb begin
    state_d    = state;
    t_cur_d    = t_cur;
    t_probe_d  = t_probe;
    hard_d     = hard;
    lat_d      = lat;
    pend_d     = grav_pend | (grav_tick && state != S_IDLE && state != S_GAMEOVER);
    field_d    = field_q;
    clean_en_d = clean_en;
    over_d     = game_over;
    next_req_d = 1'b0;
    drop_inc   = 1'b0;
    clean_upd  = 1'b0;
    sp         = next_piece;
    sp.x        = 5'(SPAWN_X);
    sp.y        = 5'(SPAWN_Y);
    sp.rotation = 2'd0;
    case (state)
      S_SPAWN: begin
        t_cur_d    = sp;
        t_probe_d  = sp;
        next_req_d = 1'b1;
        state_d    = S_SPAWN_CHK;
      end
      S_SPAWN_CHK: begin
        if (probe_ok) state_d = S_IDLE;
        else begin
          over_d  = 1'b1;
          state_d = S_GAMEOVER;
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          // The command wins; a coincident tick is deferred.
          pend_d = grav_pend | grav_tick;
          hard_d = 1'b0;
          lat_d  = 1'b1;
          case (cmd)
            CMD_LEFT:  begin t_probe_d = t_cur; t_probe_d.x = t_cur.x - 5'd1; state_d = S_PROBE; end
            CMD_RIGHT: begin t_probe_d = t_cur; t_probe_d.x = t_cur.x + 5'd1; state_d = S_PROBE; end
            CMD_ROT:   begin t_probe_d = t_cur; t_probe_d.rotation = t_cur.rotation + 2'd1; state_d = S_PROBE; end
            CMD_DOWN:  begin t_probe_d = t_cur; t_probe_d.y = t_cur.y + 5'd1; lat_d = 1'b0; state_d = S_PROBE; end
            CMD_HARD:  begin t_probe_d = t_cur; t_probe_d.y = t_cur.y + 5'd1; lat_d = 1'b0; hard_d = 1'b1; state_d = S_PROBE; end
            default:   ;
          endcase
        end else if (grav_pend || grav_tick) begin
          pend_d      = 1'b0;
          t_probe_d   = t_cur;
          t_probe_d.y = t_cur.y + 5'd1;
          hard_d      = 1'b0;
          lat_d       = 1'b0;
          state_d     = S_PROBE;
        end
      end
      S_PROBE: begin
        if (probe_ok) begin
          t_cur_d = t_probe;
          if (hard) begin
            t_probe_d.y = t_probe.y + 5'd1;
            drop_inc    = 1'b1;
          end else state_d = S_IDLE;
        end else if (lat) state_d = S_IDLE;
        else state_d = S_LOCK;
      end
      S_LOCK: begin
        field_d    = merged_field;
        clean_en_d = 1'b1;
        state_d    = S_CLEAN;
      end
      S_CLEAN: begin
        if (clean_done) begin
          field_d    = clean_field_in;
          clean_upd  = 1'b1;
          clean_en_d = 1'b0;
          state_d    = S_SPAWN;
        end
      end
      default: ;  // S_GAMEOVER: everything holds
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_SPAWN;
    else     state <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_cur     <= '0;
      t_probe   <= '0;
      field_q   <= '1;
      grav_pend <= 1'b0;
      hard      <= 1'b0;
      lat       <= 1'b0;
      clean_en  <= 1'b0;
      game_over <= 1'b0;
      next_req  <= 1'b0;
    end else begin
      t_cur     <= t_cur_d;
      t_probe   <= t_probe_d;
      field_q   <= field_d;
      grav_pend <= pend_d;
      hard      <= hard_d;
      lat       <= lat_d;
      clean_en  <= clean_en_d;
      game_over <= over_d;
      next_req  <= next_req_d;
    end
  end

  game_step_ctrl_score_keeper #(
    .SCORE_W        (SCORE_W),
    .LINES_PER_LEVEL(LINES_PER_LEVEL)
  ) u_score (
    .clk        (clk),
    .rst        (rst),
    .clean_upd  (clean_upd),
    .clean_lines(clean_lines),
    .drop_inc   (drop_inc),
    .score      (score),
    .lines_total(lines_total),
    .level      (level)
  );

endmodule

// File: tb/tb_game_step_ctrl.sv
// Scoreboard bench: stimulus queues expected piece/score state, a monitor checks each settle point.
module tb_game_step_ctrl;
  import game_step_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd = 3'd0;
  logic          grav_tick = 1'b0;
  tetromino_ctrl next_piece;
  logic          cmd_ready, next_req, probe_ok, clean_en, clean_done, game_over, busy;
  tetromino_ctrl t_probe, t_cur;
  field_t        field_q, merged_field, clean_field_in, inject;
  logic [2:0]    clean_lines;
  logic [23:0]   score;
  logic [15:0]   lines_total;
  logic [7:0]    level;

  typedef struct packed {
    logic [4:0]  x;
    logic [4:0]  y;
    logic [1:0]  rot;
    logic [23:0] score;
    logic [15:0] lines;
    logic        go;
  } exp_t;

  exp_t q[$];
  int   runs[$];
  int   chk = 0;
  int   err = 0;
  int   nreq = 0;
  int   ccnt = 0;

  game_step_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .grav_tick(grav_tick), .next_piece(next_piece), .next_req(next_req),
    .t_probe(t_probe), .probe_ok(probe_ok), .t_cur(t_cur), .field_q(field_q),
    .merged_field(merged_field), .clean_en(clean_en), .clean_done(clean_done),
    .clean_field_in(clean_field_in), .clean_lines(clean_lines), .score(score),
    .lines_total(lines_total), .level(level), .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic tetromino_ctrl mk(input logic [2:0] idx, input logic [15:0] r0, r1, r2, r3);
    tetromino_ctrl t;
    t = '0;
    t.idx = idx;
    t.tetromino[0] = r0; t.tetromino[1] = r1; t.tetromino[2] = r2; t.tetromino[3] = r3;
    return t;
  endfunction

  // check_valid model: every occupied cell in bounds and on an empty field cell.
  function automatic logic cv(input tetromino_ctrl t, input field_t f);
    logic [15:0] m;
    m = t.tetromino[t.rotation];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m[r*4+c]) begin
          if (int'(t.x) + c >= FIELD_HORIZONTAL || int'(t.y) + r >= FIELD_VERTICAL) return 1'b0;
          if (!f[int'(t.y)+r][int'(t.x)+c]) return 1'b0;
        end
    return 1'b1;
  endfunction

  // create_field model: clear the piece cells; inject lets the bench pre-fill cells.
  function automatic field_t merge(input tetromino_ctrl t, input field_t f, input field_t inj);
    field_t o;
    logic [15:0] m;
    o = f & ~inj;
    m = t.tetromino[t.rotation];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m[r*4+c] && int'(t.x) + c < FIELD_HORIZONTAL && int'(t.y) + r < FIELD_VERTICAL)
          o[int'(t.y)+r][int'(t.x)+c] = 1'b0;
    return o;
  endfunction

  always_comb probe_ok = cv(t_probe, field_q);
  always_comb merged_field = merge(t_cur, field_q, inject);

  // clean_field model: drop full rows, shift the rest down, answer after 3 enable cycles.
  always_comb begin
    int n;
    int dst;
    clean_field_in = '1;
    n = 0;
    dst = FIELD_VERTICAL - 1;
    for (int r = FIELD_VERTICAL - 1; r >= 0; r--)
      if (field_q[r] == '0) n++;
      else begin clean_field_in[dst] = field_q[r]; dst--; end
    clean_lines = 3'(n);
  end
  always @(posedge clk) ccnt <= (clean_en === 1'b1) ? ccnt + 1 : 0;
  assign clean_done = (clean_en === 1'b1) && (ccnt == 2);

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t ex(input int x, y, rot, sc, ln, go);
    exp_t e;
    e.x = 5'(x); e.y = 5'(y); e.rot = 2'(rot); e.score = 24'(sc); e.lines = 16'(ln); e.go = 1'(go);
    return e;
  endfunction

  // Monitor: every return to IDLE or entry to game over consumes one expected record.
  initial begin
    logic prev_rdy, prev_go;
    exp_t e;
    int   evn;
    prev_rdy = 1'b0; prev_go = 1'b0; evn = 0;
    forever begin
      @(negedge clk);
      if (!rst && ((cmd_ready === 1'b1 && !prev_rdy) || (game_over === 1'b1 && !prev_go))) begin
        evn++;
        if (q.size() == 0) begin
          chk++; err++;
          $display("FAIL evt%0d_unexpected act=settle exp=none", evn);
        end else begin
          e = q.pop_front();
          check($sformatf("evt%0d_x", evn), 256'(t_cur.x), 256'(e.x));
          check($sformatf("evt%0d_y", evn), 256'(t_cur.y), 256'(e.y));
          check($sformatf("evt%0d_rot", evn), 256'(t_cur.rotation), 256'(e.rot));
          check($sformatf("evt%0d_score", evn), 256'(score), 256'(e.score));
          check($sformatf("evt%0d_lines", evn), 256'(lines_total), 256'(e.lines));
          check($sformatf("evt%0d_gameover", evn), 256'(game_over), 256'(e.go));
        end
      end
      prev_rdy = (cmd_ready === 1'b1);
      prev_go  = (game_over === 1'b1);
    end
  end

  initial forever begin @(negedge clk); if (next_req === 1'b1) nreq++; end

  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (clean_en === 1'b1) run++;
      else if (run != 0) begin runs.push_back(run); run = 0; end
    end
  end

  task automatic wait_settle(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(cmd_ready === 1'b1 || game_over === 1'b1) && n < 500);
    if (n >= 500) begin chk++; err++; $display("FAIL %s_timeout act=busy exp=settled", nm); end
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic tick);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin chk++; err++; $display("FAIL cmd_ready_timeout act=0 exp=1"); end
    cmd_valid = 1'b1; cmd = c; grav_tick = tick;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = CMD_NONE;
    if (tick) begin @(posedge clk); #1; grav_tick = 1'b0; end  // second tick lands in PROBE
    wait_settle("cmd");
  endtask

  initial begin
    tetromino_ctrl pt, pi;
    field_t ef;
    pt = mk(3'd1, 16'h0027, 16'h0232, 16'h0072, 16'h0262);
    pi = mk(3'd2, 16'h000F, 16'h2222, 16'h000F, 16'h2222);
    next_piece = pt;
    inject = '0;

    // Reset state while rst is held.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_field", 256'(field_q), {36'd0, {220{1'b1}}});
    check("rst_tcur", 256'(t_cur), 256'd0);
    check("rst_tprobe", 256'(t_probe), 256'd0);
    check("rst_score", 256'(score), 256'd0);
    check("rst_flags", 256'({game_over, clean_en, next_req, cmd_ready}), 256'd0);
    q.push_back(ex(3, 0, 0, 0, 0, 0));
    rst = 1'b0;
    wait_settle("spawn");
    check("spawn_nreq", 256'(nreq), 256'd1);
    check("spawn_field", 256'(field_q), {36'd0, {220{1'b1}}});

    // Rotation steps through all four orientations.
    for (int i = 1; i <= 4; i++) begin q.push_back(ex(3, 0, i % 4, 0, 0, 0)); do_cmd(CMD_ROT, 1'b0); end

    // LEFT to the wall; the fourth is rejected.
    for (int i = 0; i < 4; i++) begin
      q.push_back(ex((i < 3) ? 2 - i : 0, 0, 0, 0, 0, 0));
      do_cmd(CMD_LEFT, 1'b0);
    end
    check("left_wall_busy", 256'(busy), 256'd0);

    // Hard drop from (0,0): 20 rows, lock at y=20.
    q.push_back(ex(3, 0, 0, 20, 0, 0));
    do_cmd(CMD_HARD, 1'b0);
    check("drop1_nreq", 256'(nreq), 256'd2);

    // RIGHT with coincident tick, another tick during PROBE: one gravity step only.
    q.push_back(ex(4, 0, 0, 20, 0, 0));
    q.push_back(ex(4, 1, 0, 20, 0, 0));
    do_cmd(CMD_RIGHT, 1'b1);
    repeat (10) @(negedge clk);
    check("grav_once_y", 256'(t_cur.y), 256'd1);

    // Drop from y=1 at x=4: 19 rows; the I piece spawns next.
    next_piece = pi;
    q.push_back(ex(3, 0, 0, 39, 0, 0));
    do_cmd(CMD_HARD, 1'b0);

    // I drop lands at y=19 (19 rows); row 19 completed by injected cells -> one line.
    next_piece = pt;
    inject[19] = 10'b1110000111;
    q.push_back(ex(3, 0, 0, 158, 1, 0));
    do_cmd(CMD_HARD, 1'b0);
    inject = '0;
    ef = '1;
    ef[20][0] = 1'b0; ef[20][1] = 1'b0; ef[20][2] = 1'b0;
    ef[20][4] = 1'b0; ef[20][5] = 1'b0; ef[20][6] = 1'b0;
    ef[21][1] = 1'b0; ef[21][5] = 1'b0;
    check("clean_field", 256'(field_q), 256'(ef));
    check("clean_level", 256'(level), 256'd0);

    // Spawn rows blocked: T drops 18 rows, next spawn fails.
    inject[0] = 10'b0001111000;
    inject[1] = 10'b0001111000;
    q.push_back(ex(3, 0, 0, 176, 1, 1));
    do_cmd(CMD_HARD, 1'b0);
    inject = '0;
    check("go_ready", 256'(cmd_ready), 256'd0);
    check("go_busy", 256'(busy), 256'd0);
    cmd_valid = 1'b1; cmd = CMD_LEFT; grav_tick = 1'b1;
    repeat (6) @(negedge clk);
    cmd_valid = 1'b0; cmd = CMD_NONE; grav_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("go_frozen_pos", 256'({t_cur.x, t_cur.y}), 256'({5'd3, 5'd0}));
    check("go_frozen_score", 256'(score), 256'd176);
    check("go_sticky", 256'(game_over), 256'd1);
    check("go_nreq", 256'(nreq), 256'd5);
    check("clean_runs_n", 256'(runs.size()), 256'd4);
    foreach (runs[i]) check($sformatf("clean_run%0d_len", i), 256'(runs[i]), 256'd3);

    // Reset recovers from game over.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst2_gameover", 256'(game_over), 256'd0);
    check("rst2_field", 256'(field_q), {36'd0, {220{1'b1}}});
    check("rst2_counts", 256'({score, lines_total, level}), 256'd0);
    q.push_back(ex(3, 0, 0, 0, 0, 0));
    rst = 1'b0;
    wait_settle("respawn");
    repeat (2) @(negedge clk);
    check("sb_drained", 256'(q.size()), 256'd0);
    check("final_nreq", 256'(nreq), 256'd6);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
